// File: rtl/pt_ring_stop_if.sv
// pt_ring_stop_if: bundles the ring, injection-FIFO and ejection signals of one
// PtRingV1 ring station. The slave modport is the station; master is its surroundings.
// Optional macro PT_RING_STOP_STAT_EN adds the three statistics counter outputs.
//
// Handshakes:
//  - Ring: iRingVld/oRingVld qualify the flit; there is no ready, a station must
//    accept every valid flit the cycle it arrives.
//  - Injection: iInjDat is valid whenever !iInjEmpty; oInjRdEn pops it that cycle.
//  - Ejection: oEjDat transfers on a cycle where oEjVld && iEjRdy; while
//    oEjVld && !iEjRdy the payload holds stable.
interface pt_ring_stop_if #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  localparam int DW = ID_W + WIDTH;

  logic             iRingVld;
  logic [DW-1:0]    iRingDat;
  logic             oRingVld;
  logic [DW-1:0]    oRingDat;
  logic             iInjEmpty;
  logic [DW-1:0]    iInjDat;
  logic             oInjRdEn;
  logic             oEjVld;
  logic [WIDTH-1:0] oEjDat;
  logic             iEjRdy;

`ifdef PT_RING_STOP_STAT_EN
  logic [CNT_W-1:0] oInjCnt;
  logic [CNT_W-1:0] oEjCnt;
  logic [CNT_W-1:0] oDflCnt;

  modport slave (
    input  iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy,
    output oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat,
    output oInjCnt, oEjCnt, oDflCnt
  );

  modport master (
    output iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy,
    input  oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat,
    input  oInjCnt, oEjCnt, oDflCnt
  );
`else
  modport slave (
    input  iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy,
    output oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat
  );

  modport master (
    output iRingVld, iRingDat, iInjEmpty, iInjDat, iEjRdy,
    input  oRingVld, oRingDat, oInjRdEn, oEjVld, oEjDat
  );
`endif
endinterface

// File: rtl/pt_ring_stop.sv
// pt_ring_stop: one station of the unidirectional, backpressure-free PtRingV1 ring.
// Forwards through-traffic, ejects local flits into a one-entry register, and
// pops the show-ahead injection FIFO into empty ring slots. A local flit that
// finds the ejection register full is deflected for another lap.
// Optional macro PT_RING_STOP_STAT_EN adds saturating inject/eject/deflect counters.
module pt_ring_stop #(
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int NODE_ID = 0,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  pt_ring_stop_if.slave bus
);
  localparam int DW = ID_W + WIDTH;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);

  logic             hit;
  logic             ej_free;
  logic             eject;
  logic             slot_free;
  logic             inject;
  logic             ring_vld;
  logic [DW-1:0]    ring_dat;
  logic             ej_vld;
  logic [WIDTH-1:0] ej_dat;

  // Per-cycle routing decision: eject, pass through, and whether the slot is free to inject.
  always_comb begin
    hit       = bus.iRingVld && (bus.iRingDat[DW-1 -: ID_W] == MY_ID);
    ej_free   = !ej_vld || bus.iEjRdy;
    eject     = hit && ej_free;
    slot_free = !bus.iRingVld || eject;
    inject    = slot_free && !bus.iInjEmpty && !rst;
  end

  // Ring output register: through/deflected traffic has priority over injection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_vld <= 1'b0;
      ring_dat <= '0;
    end else if (bus.iRingVld && !eject) begin
      ring_vld <= 1'b1;
      ring_dat <= bus.iRingDat;
    end else if (inject) begin
      ring_vld <= 1'b1;
      ring_dat <= bus.iInjDat;
    end else begin
      ring_vld <= 1'b0;
    end
  end

  // Ejection register: refill on eject (also while draining), clear once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      ej_vld <= 1'b0;
      ej_dat <= '0;
    end else if (eject) begin
      ej_vld <= 1'b1;
      ej_dat <= bus.iRingDat[WIDTH-1:0];
    end else if (bus.iEjRdy) begin
      ej_vld <= 1'b0;
    end
  end

  assign bus.oRingVld = ring_vld;
  assign bus.oRingDat = ring_dat;
  assign bus.oInjRdEn = inject;
  assign bus.oEjVld   = ej_vld;
  assign bus.oEjDat   = ej_dat;

`ifdef PT_RING_STOP_STAT_EN
  logic             deflect;
  logic [CNT_W-1:0] inj_cnt;
  logic [CNT_W-1:0] ej_cnt;
  logic [CNT_W-1:0] dfl_cnt;

  assign deflect = hit && !ej_free;

  // Event counters, each sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt <= '0;
      ej_cnt  <= '0;
      dfl_cnt <= '0;
    end else begin
      if (inject && (inj_cnt != '1)) inj_cnt <= inj_cnt + CNT_W'(1);
      if (eject && (ej_cnt != '1))   ej_cnt  <= ej_cnt + CNT_W'(1);
      if (deflect && (dfl_cnt != '1)) dfl_cnt <= dfl_cnt + CNT_W'(1);
    end
  end

  assign bus.oInjCnt = inj_cnt;
  assign bus.oEjCnt  = ej_cnt;
  assign bus.oDflCnt = dfl_cnt;
`endif
endmodule

// File: tb/tb_pt_ring_stop.sv
// tb_pt_ring_stop: directed bench for pt_ring_stop (NODE_ID=0). A queue-based
// flit model predicts outputs every cycle; directed steps pin literal values.
// With PT_RING_STOP_STAT_EN defined the counters are checked too (CNT_W=2).
module tb_pt_ring_stop;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;
  localparam int NODE_ID = 0;
`ifdef PT_RING_STOP_STAT_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 16;
`endif
  localparam int DW = ID_W + WIDTH;

  logic clk;
  logic rst;

  pt_ring_stop_if #(.WIDTH(WIDTH), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  pt_ring_stop #(.WIDTH(WIDTH), .ID_W(ID_W), .NODE_ID(NODE_ID), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- injection FIFO environment ----------------
  logic [DW-1:0] inj_q[$];
  logic          pop_seen = 1'b0;

  task automatic upd_fifo();
    bus.iInjEmpty = (inj_q.size() == 0);
    bus.iInjDat   = (inj_q.size() != 0) ? inj_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] f);
    inj_q.push_back(f);
    upd_fifo();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic rv, input logic [DW-1:0] rd, input logic ejr);
    bus.iRingVld = rv;
    bus.iRingDat = rd;
    bus.iEjRdy   = ejr;
  endtask

  task automatic tick();
    logic [DW-1:0] junk;
    @(posedge clk);
    #1;
    if (pop_seen && inj_q.size() != 0) junk = inj_q.pop_front();
    upd_fifo();
  endtask

  // ---------------- scoreboard / flit model ----------------
  logic             m_valid = 1'b0;
  logic             m_ring_vld;
  logic [DW-1:0]    m_ring_dat;
  logic [WIDTH-1:0] ej_q[$];
  logic [WIDTH-1:0] m_ej_last;
  int               m_inj_cnt, m_ej_cnt, m_dfl_cnt;
  logic             drain, room, is_local, taken, exp_pop;
  int               cnt_max;

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  always @(negedge clk) begin
    cnt_max  = (1 << CNT_W) - 1;
    pop_seen = bus.oInjRdEn;
    drain    = (ej_q.size() != 0) && bus.iEjRdy;
    room     = (ej_q.size() == 0) || drain;
    is_local = bus.iRingVld && (int'(bus.iRingDat[DW-1 -: ID_W]) == NODE_ID);
    taken    = is_local && room;
    exp_pop  = !rst && (!bus.iRingVld || taken) && !bus.iInjEmpty;

    if (m_valid) begin
      chk("inj_rd_en", 32'(bus.oInjRdEn), 32'(exp_pop));
      chk("ring_vld", 32'(bus.oRingVld), 32'(m_ring_vld));
      chk("ring_dat", 32'(bus.oRingDat), 32'(m_ring_dat));
      chk("ej_vld", 32'(bus.oEjVld), 32'(ej_q.size() != 0));
      chk("ej_dat", 32'(bus.oEjDat), 32'(m_ej_last));
`ifdef PT_RING_STOP_STAT_EN
      chk("inj_cnt", 32'(bus.oInjCnt), 32'(m_inj_cnt));
      chk("ej_cnt", 32'(bus.oEjCnt), 32'(m_ej_cnt));
      chk("dfl_cnt", 32'(bus.oDflCnt), 32'(m_dfl_cnt));
`endif
    end

    if (rst) begin
      m_valid    = 1'b1;
      m_ring_vld = 1'b0;
      m_ring_dat = '0;
      ej_q.delete();
      m_ej_last  = '0;
      m_inj_cnt  = 0;
      m_ej_cnt   = 0;
      m_dfl_cnt  = 0;
    end else if (m_valid) begin
      if (drain) void'(ej_q.pop_front());
      if (taken) begin
        ej_q.push_back(bus.iRingDat[WIDTH-1:0]);
        m_ej_last = bus.iRingDat[WIDTH-1:0];
        m_ej_cnt  = sat_inc(m_ej_cnt, cnt_max);
      end else if (is_local) begin
        m_dfl_cnt = sat_inc(m_dfl_cnt, cnt_max);
      end
      if (bus.iRingVld && !taken) begin
        m_ring_vld = 1'b1;
        m_ring_dat = bus.iRingDat;
      end else if (exp_pop) begin
        m_ring_vld = 1'b1;
        m_ring_dat = bus.iInjDat;
        m_inj_cnt  = sat_inc(m_inj_cnt, cnt_max);
      end else begin
        m_ring_vld = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(1'b0, '0, 1'b1);
    upd_fifo();
    tick();
    tick();
    chk("rst_ring_vld", 32'(bus.oRingVld), 32'd0);
    chk("rst_ring_dat", 32'(bus.oRingDat), 32'd0);
    chk("rst_ej_vld", 32'(bus.oEjVld), 32'd0);
    chk("rst_ej_dat", 32'(bus.oEjDat), 32'd0);
    rst = 1'b0;

    // through traffic
    set_in(1'b1, {2'd2, 8'h5A}, 1'b1);
    tick();
    chk("t1_ring_vld", 32'(bus.oRingVld), 32'd1);
    chk("t1_ring_dat", 32'(bus.oRingDat), 32'h25A);
    chk("t1_ej_vld", 32'(bus.oEjVld), 32'd0);

    // eject + inject in the same cycle
    push({2'd1, 8'h11});
    set_in(1'b1, {2'd0, 8'h33}, 1'b1);
    #1;
    chk("t2_pop", 32'(bus.oInjRdEn), 32'd1);
    tick();
    chk("t2_ej_vld", 32'(bus.oEjVld), 32'd1);
    chk("t2_ej_dat", 32'(bus.oEjDat), 32'h33);
    chk("t2_ring_dat", 32'(bus.oRingDat), 32'h111);

    // deflection while the sink stalls
    set_in(1'b1, {2'd0, 8'h44}, 1'b0);
    tick();
    chk("t3_ring_dat", 32'(bus.oRingDat), 32'h044);
    chk("t3_ej_dat", 32'(bus.oEjDat), 32'h33);
    chk("t3_ej_vld", 32'(bus.oEjVld), 32'd1);
`ifdef PT_RING_STOP_STAT_EN
    chk("t3_dfl_cnt", 32'(bus.oDflCnt), 32'd1);
`endif
    set_in(1'b0, '0, 1'b1);
    tick();
    chk("t3_drained", 32'(bus.oEjVld), 32'd0);

    // saturated ring blocks injection
    push({2'd3, 8'hA5});
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, {2'd1, 8'(i)}, 1'b1);
      #1;
      chk("t4_blocked", 32'(bus.oInjRdEn), 32'd0);
      tick();
    end
    set_in(1'b0, '0, 1'b1);
    #1;
    chk("t4_pop", 32'(bus.oInjRdEn), 32'd1);
    tick();
    chk("t4_ring_vld", 32'(bus.oRingVld), 32'd1);
    chk("t4_ring_dat", 32'(bus.oRingDat), 32'h3A5);

    // reset mid-operation
    push({2'd1, 8'hB1});
    push({2'd2, 8'hB2});
    set_in(1'b1, {2'd0, 8'h77}, 1'b1);
    tick();
    chk("t5_pre_ej", 32'(bus.oEjVld), 32'd1);
    chk("t5_pre_ring", 32'(bus.oRingDat), 32'h1B1);
    rst = 1'b1;
    set_in(1'b1, {2'd2, 8'h01}, 1'b0);
    #1;
    chk("t5_no_pop", 32'(bus.oInjRdEn), 32'd0);
    tick();
    rst = 1'b0;
    chk("t5_ring_vld", 32'(bus.oRingVld), 32'd0);
    chk("t5_ej_vld", 32'(bus.oEjVld), 32'd0);
    chk("t5_ej_dat", 32'(bus.oEjDat), 32'd0);
    set_in(1'b0, '0, 1'b1);
    #1;
    chk("t5_pop", 32'(bus.oInjRdEn), 32'd1);
    tick();
    chk("t5_ring_dat", 32'(bus.oRingDat), 32'h2B2);

    // self-addressed flit: injected, then seen again after its lap
    push({2'd0, 8'hC3});
    tick();
    chk("self_ring_dat", 32'(bus.oRingDat), 32'h0C3);
    set_in(1'b1, {2'd0, 8'hC3}, 1'b1);
    tick();
    chk("self_ej_dat", 32'(bus.oEjDat), 32'hC3);

    // mixed traffic table, checked by the model every cycle
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) push({2'((i * 7) % 4), 8'(i * 13)});
      set_in((i % 3) != 0, {2'(i % 4), 8'(8'hC0 + i)}, (i % 5) != 1);
      tick();
    end
    set_in(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    chk("flush_empty", 32'(bus.iInjEmpty), 32'd1);

`ifdef PT_RING_STOP_STAT_EN
    // counter saturation and reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push({2'd3, 8'(i)});
    for (int i = 0; i < 5; i++) tick();
    chk("t6_inj_sat", 32'(bus.oInjCnt), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_inj_rst", 32'(bus.oInjCnt), 32'h0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
